// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB types, PID/SYNC bytes, CRC16 constants and line encodings
package usb_pkg;

   typedef enum logic [1:0] {
      PKT_ACK   = 2'd0,
      PKT_NAK   = 2'd1,
      PKT_DATA  = 2'd2,
      PKT_STALL = 2'd3
   } tx_packet_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_DATA,
      ST_CRC_LO,
      ST_CRC_HI,
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_t;

   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] SYNC_BYTE = 8'h80;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   // {D+, D-}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// rtl/usb_crc16_serial.sv - bit-serial CRC16 (x^16+x^15+x^2+1), shared by TX and RX paths
module usb_crc16_serial (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clear,
   input  logic        shift_en,
   input  logic        bit_in,
   output logic [15:0] crc
);
   import usb_pkg::*;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         crc <= CRC16_INIT;
      end else if (clear) begin
         crc <= CRC16_INIT;
      end else if (shift_en) begin
         crc <= {crc[14:0], 1'b0} ^ ((bit_in ^ crc[15]) ? CRC16_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB full-speed packet transmitter: SYNC/PID/payload/CRC16,
// bit stuffing, NRZI and EOP onto D+/D-
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 4,
   parameter int MAX_PAYLOAD  = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [1:0] tx_packet,
   input  logic       data_pid_sel,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_packet_data,
   output logic       dplus_out,
   output logic       dminus_out,
   output logic       tx_transfer_active,
   output logic       tx_error
);
   import usb_pkg::*;

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   tx_state_t   state, state_next;
   tx_packet_t  pkt;
   logic        pid_sel, start_q, accept, stuffing, abort, get_q, err_q;
   logic [6:0]  len, byte_cnt, data_len;
   logic [2:0]  bit_idx, bit_idx_next, ones_cnt, ones_next;
   logic [CW-1:0] clk_cnt;
   logic [7:0]  tx_byte, pid_byte, nxt_byte;
   logic [1:0]  line;
   logic [15:0] crc;
   logic        slot_end, in_bits, hold, move, crc_shift, nxt_bit;

   usb_crc16_serial u_crc (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (accept),
      .shift_en (crc_shift),
      .bit_in   (tx_byte[bit_idx]),
      .crc      (crc)
   );

   assign accept    = tx_start && (state == ST_IDLE) && !start_q;
   assign data_len  = (buffer_occupancy > 7'(MAX_PAYLOAD)) ? 7'(MAX_PAYLOAD) : buffer_occupancy;
   assign slot_end  = (state != ST_IDLE) && (clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign in_bits   = state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI};
   assign ones_next = tx_byte[bit_idx] ? ones_cnt + 3'd1 : 3'd0;
   // A stuffed slot keeps the bit position; the position moves on when it ends.
   assign hold      = slot_end && in_bits && !stuffing && !abort && (ones_next == 3'd6);
   assign move      = (state == ST_IDLE) ? start_q : (slot_end && !hold);
   // Payload byte is loaded during the pop cycle, so the CRC consumes each bit one clk later.
   assign crc_shift = (state == ST_DATA) && !stuffing && !abort && (clk_cnt == CW'(1));

   always_comb begin
      case (pkt)
         PKT_ACK:   pid_byte = PID_ACK;
         PKT_NAK:   pid_byte = PID_NAK;
         PKT_STALL: pid_byte = PID_STALL;
         default:   pid_byte = pid_sel ? PID_DATA1 : PID_DATA0;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (state == ST_IDLE) begin
         if (start_q) state_next = ST_SYNC;
      end else if (move) begin
         if (abort && state == ST_DATA) begin
            state_next = ST_EOP_SE0;
         end else begin
            case (state)
               ST_SYNC:    if (bit_idx == 3'd7) state_next = ST_PID;
               ST_PID:     if (bit_idx == 3'd7)
                              state_next = (pkt != PKT_DATA) ? ST_EOP_SE0 :
                                           (len != 7'd0)     ? ST_DATA : ST_CRC_LO;
               ST_DATA:    if (bit_idx == 3'd7 && (byte_cnt + 7'd1) == len) state_next = ST_CRC_LO;
               ST_CRC_LO:  if (bit_idx == 3'd7) state_next = ST_CRC_HI;
               ST_CRC_HI:  if (bit_idx == 3'd7) state_next = ST_EOP_SE0;
               ST_EOP_SE0: if (bit_idx == 3'd1) state_next = ST_EOP_J;
               default:    state_next = ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      tx_transfer_active = (state != ST_IDLE);
      dplus_out          = line[1];
      dminus_out         = line[0];
      get_tx_packet_data = get_q;
      tx_error           = err_q;
   end

   // The CRC is transmitted complemented, highest-order coefficient first.
   always_comb begin
      bit_idx_next = (state_next != state) ? 3'd0 : bit_idx + 3'd1;
      case (state_next)
         ST_SYNC:   nxt_byte = SYNC_BYTE;
         ST_PID:    nxt_byte = pid_byte;
         ST_DATA:   nxt_byte = (bit_idx_next == 3'd0) ? tx_packet_data : tx_byte;
         ST_CRC_LO: nxt_byte = rev8(~crc[15:8]);
         ST_CRC_HI: nxt_byte = rev8(~crc[7:0]);
         default:   nxt_byte = tx_byte;
      endcase
      nxt_bit = nxt_byte[bit_idx_next];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         start_q  <= 1'b0;
         pkt      <= PKT_ACK;
         pid_sel  <= 1'b0;
         len      <= 7'd0;
         byte_cnt <= 7'd0;
         bit_idx  <= 3'd0;
         clk_cnt  <= '0;
         ones_cnt <= 3'd0;
         stuffing <= 1'b0;
         tx_byte  <= 8'h00;
         line     <= LINE_J;
         get_q    <= 1'b0;
         abort    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         start_q <= accept;
         get_q   <= 1'b0;
         if (accept) begin
            pkt      <= tx_packet_t'(tx_packet);
            pid_sel  <= data_pid_sel;
            len      <= (tx_packet == PKT_DATA) ? data_len : 7'd0;
            err_q    <= 1'b0;
            abort    <= 1'b0;
            byte_cnt <= 7'd0;
            ones_cnt <= 3'd0;
            stuffing <= 1'b0;
         end
         if (state == ST_IDLE || slot_end) clk_cnt <= '0;
         else                              clk_cnt <= clk_cnt + CW'(1);
         if (slot_end && in_bits && !stuffing) ones_cnt <= hold ? 3'd0 : ones_next;
         if (hold) begin
            stuffing <= 1'b1;
            line     <= ~line;
         end
         if (move) begin
            stuffing <= 1'b0;
            bit_idx  <= bit_idx_next;
            tx_byte  <= nxt_byte;
            if (state == ST_DATA && bit_idx == 3'd7 && !abort) byte_cnt <= byte_cnt + 7'd1;
            get_q <= (state_next == ST_DATA) && (bit_idx_next == 3'd0);
            case (state_next)
               ST_EOP_SE0:       line <= LINE_SE0;
               ST_EOP_J, ST_IDLE: line <= LINE_J;
               default:          line <= nxt_bit ? line : ~line;
            endcase
         end
         if (get_q) begin
            tx_byte <= tx_packet_data;
            if (buffer_occupancy == 7'd0) begin
               abort <= 1'b1;
               err_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb/tb_usb_tx_encoder.sv - directed bench: decodes D+/D- (NRZI, destuff, EOP) and checks packets
module tb_usb_tx_encoder;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_start = 1'b0;
   logic [1:0] tx_packet = 2'd0;
   logic       data_pid_sel = 1'b0;
   logic [6:0] buffer_occupancy;
   logic [7:0] tx_packet_data;
   logic       get_tx_packet_data, dplus_out, dminus_out, tx_transfer_active, tx_error;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo [0:127];
   int  fifo_len = 0;
   int  fifo_rd = 0;
   bit  force_zero = 0;
   int  zero_at = 0;
   int  pops = 0;
   int  pop_idx[$];
   logic [1:0] samples[$];
   bit  bits[$];
   int  stuffs;

   usb_tx_encoder #(.CLKS_PER_BIT(4), .MAX_PAYLOAD(64)) dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .tx_start           (tx_start),
      .tx_packet          (tx_packet),
      .data_pid_sel       (data_pid_sel),
      .buffer_occupancy   (buffer_occupancy),
      .tx_packet_data     (tx_packet_data),
      .get_tx_packet_data (get_tx_packet_data),
      .dplus_out          (dplus_out),
      .dminus_out         (dminus_out),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error)
   );

   always #5 clk = ~clk;

   assign buffer_occupancy = (force_zero || fifo_rd >= fifo_len) ? 7'd0 : 7'(fifo_len - fifo_rd);
   assign tx_packet_data   = fifo[fifo_rd[6:0]];

   // Line sampler and FIFO model: the head advances just after the edge that ends the pop cycle.
   always @(negedge clk) begin
      if (tx_transfer_active) begin
         if (get_tx_packet_data) pop_idx.push_back(samples.size());
         samples.push_back({dplus_out, dminus_out});
      end
      if (get_tx_packet_data) begin
         pops++;
         @(posedge clk);
         #1;
         fifo_rd++;
         if (zero_at > 0 && pops == zero_at) force_zero = 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input int k);
      logic [7:0] v = 8'h00;
      for (int i = 0; i < 8; i++)
         if (8*k + i < bits.size()) v[i] = bits[8*k + i];
      return v;
   endfunction

   function automatic logic [15:0] residual();
      logic [15:0] c = 16'hFFFF;
      logic fb;
      for (int i = 16; i < bits.size(); i++) begin
         fb = bits[i] ^ c[15];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return c;
   endfunction

   task automatic run_packet(input logic [1:0] ptype, input logic psel, input int nbytes,
                             input int glitch_at, input int zero_after, input int reset_at);
      int  cyc = 0;
      bit  done = 0;
      samples.delete();
      pop_idx.delete();
      pops = 0;
      fifo_rd = 0;
      fifo_len = nbytes;
      force_zero = 0;
      zero_at = zero_after;
      @(negedge clk);
      tx_packet = ptype;
      data_pid_sel = psel;
      tx_start = 1'b1;
      while (cyc < 4000 && !done) begin
         @(negedge clk);
         cyc++;
         tx_start = (cyc == glitch_at);
         if (cyc == 1) check("start_latency", tx_transfer_active, 0);
         if (cyc == 2) begin
            check("active_rise", tx_transfer_active, 1);
            check("err_clear", tx_error, 0);
         end
         if (cyc == reset_at) begin
            n_rst = 1'b0;
            #1;
            check("rst_lines", {dplus_out, dminus_out}, 2'b10);
            check("rst_active", tx_transfer_active, 0);
            check("rst_get", get_tx_packet_data, 0);
            @(negedge clk);
            n_rst = 1'b1;
            done = 1;
         end else if (cyc > 2 && !tx_transfer_active) begin
            done = 1;
         end
      end
      check("end_seen", done, 1);
   endtask

   task automatic decode_check(input string tag, input logic [7:0] exp_pid);
      logic [1:0] prev = 2'b10;
      int ones = 0, eop = -1, unstable = 0, bad_stuff = 0, nslots;
      bit b, eop_ok;
      stuffs = 0;
      bits.delete();
      nslots = samples.size() / 4;
      for (int s = 0; s < nslots; s++) begin
         for (int k = 1; k < 4; k++)
            if (samples[4*s + k] !== samples[4*s]) unstable++;
         if (eop < 0) begin
            if (samples[4*s] == 2'b00) begin
               eop = s;
            end else begin
               b = (samples[4*s] == prev);
               prev = samples[4*s];
               if (ones == 6) begin
                  stuffs++;
                  if (b) bad_stuff++;
                  ones = 0;
               end else begin
                  bits.push_back(b);
                  ones = b ? ones + 1 : 0;
               end
            end
         end
      end
      eop_ok = 0;
      if (eop >= 0 && eop + 3 == nslots)
         eop_ok = (samples[4*eop + 4] == 2'b00) && (samples[4*eop + 8] == 2'b10);
      check({tag, "_stable"}, unstable, 0);
      check({tag, "_whole_slots"}, samples.size() % 4, 0);
      check({tag, "_stuff_bits"}, bad_stuff, 0);
      check({tag, "_sync"}, get_byte(0), 8'h80);
      check({tag, "_pid"}, get_byte(1), exp_pid);
      check({tag, "_eop"}, eop_ok, 1);
      check({tag, "_byte_align"}, bits.size() % 8, 0);
   endtask

   task automatic check_payload(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (get_byte(2 + i) !== fifo[i]) bad++;
      check({tag, "_payload"}, bad, 0);
      check({tag, "_len"}, bits.size(), 8 * (n + 4));
      check({tag, "_residual"}, residual(), 16'h800D);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_lines", {dplus_out, dminus_out}, 2'b10);
      check("reset_active", tx_transfer_active, 0);
      check("reset_err", tx_error, 0);
      check("reset_get", get_tx_packet_data, 0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      // ACK, with a second request mid-packet that must be ignored
      run_packet(2'd0, 1'b0, 0, 20, 0, 0);
      decode_check("ack", 8'hD2);
      check("ack_clks", samples.size(), 76);
      check("ack_pops", pops, 0);
      repeat (10) @(negedge clk);
      check("ack_no_retrigger", tx_transfer_active, 0);

      // zero-length DATA0
      run_packet(2'd2, 1'b0, 0, 0, 0, 0);
      decode_check("zlp", 8'hC3);
      check("zlp_slots", samples.size(), 35 * 4);
      check("zlp_crc", {get_byte(2), get_byte(3)}, 16'h0000);
      check("zlp_pops", pops, 0);

      // DATA1 with three 0xFF bytes exercises stuffing
      for (int i = 0; i < 3; i++) fifo[i] = 8'hFF;
      run_packet(2'd2, 1'b1, 3, 0, 0, 0);
      decode_check("stuff", 8'h4B);
      check_payload("stuff", 3);
      check("stuff_pops", pops, 3);
      check("stuff_min", (stuffs >= 4), 1);
      check("stuff_slots", samples.size(), 4 * (3 + 8 * 7 + stuffs));

      // 70 bytes queued, only 64 go out
      for (int i = 0; i < 70; i++) fifo[i] = 8'((i * 29 + 7) & 8'hFF);
      run_packet(2'd2, 1'b0, 70, 0, 0, 0);
      decode_check("cap", 8'hC3);
      check_payload("cap", 64);
      check("cap_pops", pops, 64);
      check("cap_err", tx_error, 0);

      // underrun at the third pop
      for (int i = 0; i < 5; i++) fifo[i] = 8'(8'h30 + i);
      run_packet(2'd2, 1'b1, 5, 0, 2, 0);
      check("urun_err", tx_error, 1);
      check("urun_pops", pops, 3);
      if (pop_idx.size() >= 3) begin
         check("urun_eop_edge", {samples[pop_idx[2] + 3] != 2'b00, samples[pop_idx[2] + 4]}, 3'b100);
         check("urun_tail", samples.size(), pop_idx[2] + 16);
      end else begin
         check("urun_pop_seen", pop_idx.size(), 3);
      end

      // next accepted request clears the error
      run_packet(2'd1, 1'b0, 0, 0, 0, 0);
      decode_check("nak", 8'h5A);
      check("nak_err", tx_error, 0);
      check("nak_clks", samples.size(), 76);

      // reset in the middle of a payload byte, then a normal ACK
      for (int i = 0; i < 4; i++) fifo[i] = 8'(8'hA0 + i);
      run_packet(2'd2, 1'b0, 4, 0, 0, 80);
      repeat (2) @(negedge clk);
      run_packet(2'd0, 1'b0, 0, 0, 0, 0);
      decode_check("ack2", 8'hD2);
      check("ack2_clks", samples.size(), 76);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
